rvj1_ifu: RTL and testbench



---
 rtl/rvj1_ifu.sv | 146 ++++++++++++++
 tb/tb_rvj1_ifu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvj1_ifu.sv
// Instruction fetch unit: sequential prefetch from the last redirect target into a
// small in-order buffer; responses still in flight at a redirect are dropped by order.
module rvj1_ifu #(
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            jmp_addr_valid_i,
    input  logic [XLEN-1:0] jmp_addr_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_addr_o,
    output logic            instr_valid_o,
    output logic            instr_issued_o,
    output logic            dbg_state_o
);
    // Handshakes: a request transfers on a cycle with imem_req_o && imem_gnt_i, a response
    // on each imem_rvalid_i cycle (in order), and an instruction on instr_valid_o && ~stall_i.
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

    state_e          state_q, state_d;
    logic            fetch_en;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] resp_addr_q, resp_addr_d;
    logic [CW-1:0]   live_q, live_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] data_q [FIFO_DEPTH];
    logic [XLEN-1:0] addr_q [FIFO_DEPTH];
    logic            gnt_fire;
    logic            rsp_live;
    logic            rsp_stale;
    logic            push;
    logic            pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (jmp_addr_valid_i) state_d = FETCH;
            FETCH:   state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_en    = (state_q == FETCH);
        dbg_state_o = fetch_en;
    end

    always_comb begin
        imem_req_o     = fetch_en && !jmp_addr_valid_i
                         && ((int'(count_q) + int'(live_q)) < FIFO_DEPTH);
        imem_addr_o    = fetch_addr_q;
        instr_valid_o  = (count_q != '0) && !jmp_addr_valid_i;
        instr_issued_o = instr_valid_o && !stall_i;
        instr_o        = data_q[rd_ptr_q];
        instr_addr_o   = addr_q[rd_ptr_q];
        gnt_fire       = imem_req_o && imem_gnt_i;
        rsp_stale      = imem_rvalid_i && (discard_q != '0);
        rsp_live       = imem_rvalid_i && (discard_q == '0);
        push           = rsp_live && !jmp_addr_valid_i;
        pop            = instr_issued_o;
    end

    // Live responses return in request order, so their address is just a second
    // sequential pointer restarted at the redirect target.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        resp_addr_d  = resp_addr_q;
        live_d       = live_q;
        discard_d    = discard_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        if (jmp_addr_valid_i) begin
            fetch_addr_d = {jmp_addr_i[XLEN-1:2], 2'b00};
            resp_addr_d  = {jmp_addr_i[XLEN-1:2], 2'b00};
            live_d       = '0;
            discard_d    = discard_q + live_q - CW'(imem_rvalid_i);
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            if (gnt_fire) fetch_addr_d = fetch_addr_q + XLEN'(4);
            live_d    = live_q + CW'(gnt_fire) - CW'(rsp_live);
            discard_d = discard_q - CW'(rsp_stale);
            if (push) begin
                resp_addr_d = resp_addr_q + XLEN'(4);
                wr_ptr_d    = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr_q <= '0;
            resp_addr_q  <= '0;
            live_q       <= '0;
            discard_q    <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            fetch_addr_q <= fetch_addr_d;
            resp_addr_q  <= resp_addr_d;
            live_q       <= live_d;
            discard_q    <= discard_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            if (push) begin
                data_q[wr_ptr_q] <= imem_rdata_i;
                addr_q[wr_ptr_q] <= resp_addr_q;
            end
        end
    end

    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && (int'(count_q) == FIFO_DEPTH) && !pop));

endmodule

// File: tb/tb_rvj1_ifu.sv
// Directed bench for rvj1_ifu: an in-order memory model tags each request with a
// redirect epoch; only current-epoch responses enter the expected instruction queue.
module tb_rvj1_ifu;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        jmp_addr_valid_i = 1'b0;
  logic [31:0] jmp_addr_i = '0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;
  logic        instr_valid_o;
  logic        instr_issued_o;
  logic        dbg_state_o;

  rvj1_ifu #(.FIFO_DEPTH(2), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .jmp_addr_valid_i(jmp_addr_valid_i), .jmp_addr_i(jmp_addr_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o),
    .instr_issued_o(instr_issued_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dut_addr;
    logic [31:0] exp_addr;
    int          epoch;
    int          due;
  } rsp_t;

  rsp_t        pend[$];
  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  bit          lat_rand = 1'b0;
  bit          gnt_rand = 1'b0;
  logic [31:0] exp_fetch = '0;
  bit          req_wait = 1'b0;
  logic [31:0] req_wait_addr = '0;
  int          issues = 0;
  bit          track_first = 1'b0;
  bit          first_seen = 1'b0;
  logic [31:0] first_addr = '0;
  bit          collide_mode = 1'b0;
  bit          collided = 1'b0;
  logic [31:0] collide_tgt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs 1 time unit after the edge, sample 1 unit later.
  task automatic tick(input logic jmp, input logic [31:0] tgt, input logic stall, input logic rst);
    rsp_t        rsp;
    bit          have_rsp;
    int          l;
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (collide_mode && !rst && instr_valid_o && pend.size() > 0
        && pend[0].epoch == epoch && pend[0].due <= cyc) begin
      jmp = 1'b1;
      tgt = collide_tgt;
      collide_mode = 1'b0;
      collided = 1'b1;
    end
    rst_i = rst;
    jmp_addr_valid_i = jmp;
    jmp_addr_i = tgt;
    stall_i = stall;
    imem_gnt_i = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    have_rsp = 1'b0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      rsp = pend.pop_front();
      have_rsp = 1'b1;
      imem_rvalid_i = 1'b1;
      imem_rdata_i = mem_word(rsp.dut_addr);
    end
    #1;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      epoch++;
      req_wait = 1'b0;
      return;
    end
    if (jmp) begin
      check("jmp_req_low", 64'(imem_req_o), 64'(0));
      check("jmp_valid_low", 64'(instr_valid_o), 64'(0));
    end
    if (req_wait && !jmp) check("req_hold", {31'(0), imem_req_o, imem_addr_o}, {31'(0), 1'b1, req_wait_addr});
    if (instr_issued_o) begin
      check("issue_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("issue", {instr_addr_o, instr_o}, e);
      end
      issues++;
      if (track_first && !first_seen) begin
        first_seen = 1'b1;
        first_addr = instr_addr_o;
      end
    end
    if (imem_req_o && imem_gnt_i) begin
      check("req_addr", 64'(imem_addr_o), 64'(exp_fetch));
      l = lat_rand ? int'($urandom_range(1, 3)) : lat;
      pend.push_back('{dut_addr: imem_addr_o, exp_addr: exp_fetch, epoch: epoch, due: cyc + l});
      exp_fetch = exp_fetch + 32'd4;
    end
    req_wait = imem_req_o && !imem_gnt_i;
    req_wait_addr = imem_addr_o;
    if (jmp) begin
      epoch++;
      exp_q.delete();
      exp_fetch = {tgt[31:2], 2'b00};
    end else if (have_rsp && rsp.epoch == epoch) begin
      exp_q.push_back({rsp.exp_addr, mem_word(rsp.exp_addr)});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] held;
    int          n_live;
    int          base;

    // Reset and idle
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    check("rst_req", 64'(imem_req_o), 64'(0));
    check("rst_valid", 64'(instr_valid_o), 64'(0));
    check("rst_issued", 64'(instr_issued_o), 64'(0));
    check("rst_addr", 64'(imem_addr_o), 64'(0));
    check("rst_state", 64'(dbg_state_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("idle_req", 64'(imem_req_o), 64'(0));
      check("idle_valid", 64'(instr_valid_o), 64'(0));
    end

    // Boot to 0x8000_0000: first instruction three cycles after the jump
    lat = 1;
    tick(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("boot_state", 64'(dbg_state_o), 64'(1));
    check("boot_req", {31'(0), imem_req_o, imem_addr_o}, {31'(0), 1'b1, 32'h8000_0000});
    check("boot_valid_t1", 64'(instr_valid_o), 64'(0));
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("boot_valid_t2", 64'(instr_valid_o), 64'(0));
    check("boot_req2", 64'(imem_addr_o), 64'h8000_0004);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("boot_valid_t3", 64'(instr_valid_o), 64'(1));
    check("boot_head", {instr_addr_o, instr_o}, {32'h8000_0000, mem_word(32'h8000_0000)});
    base = issues;
    for (int i = 0; i < 20; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("boot_stream", 64'((issues - base) >= 12), 64'(1));

    // Stall until full: no requests, head held; two issues on release
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      if (i == 4) begin
        held = {instr_addr_o, instr_o};
        check("stall_head", held, exp_q[0]);
      end
      if (i >= 5) begin
        check("stall_req_low", 64'(imem_req_o), 64'(0));
        check("stall_valid", 64'(instr_valid_o), 64'(1));
        check("stall_no_issue", 64'(instr_issued_o), 64'(0));
        check("stall_hold", {instr_addr_o, instr_o}, held);
      end
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("release_issue0", 64'(instr_issued_o), 64'(1));
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("release_issue1", 64'(instr_issued_o), 64'(1));
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("release_empty", 64'(instr_issued_o), 64'(0));
    base = issues;
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("release_stream", 64'((issues - base) >= 5), 64'(1));

    // Redirect with two requests in flight
    lat = 3;
    tick(1'b1, 32'h0000_2000, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    n_live = 0;
    foreach (pend[k]) if (pend[k].epoch == epoch) n_live++;
    check("inflight_two", 64'(n_live), 64'(2));
    track_first = 1'b1;
    first_seen = 1'b0;
    tick(1'b1, 32'h0000_0100, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("redirect_seen", 64'(first_seen), 64'(1));
    check("redirect_first", 64'(first_addr), 64'h0000_0100);

    // Misaligned target and address wrap
    lat = 1;
    first_seen = 1'b0;
    tick(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_addr0", {31'(0), imem_req_o, imem_addr_o}, {31'(0), 1'b1, 32'hFFFF_FFFC});
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_addr1", {31'(0), imem_req_o, imem_addr_o}, {31'(0), 1'b1, 32'h0000_0000});
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_first", {31'(0), first_seen, first_addr}, {31'(0), 1'b1, 32'hFFFF_FFFC});
    track_first = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);

    // Redirect coinciding with a live response and a pending pop
    collide_tgt = 32'h0000_0400;
    collided = 1'b0;
    collide_mode = 1'b1;
    for (int i = 0; i < 20 && !collided; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    collide_mode = 1'b0;
    check("collide_found", 64'(collided), 64'(1));
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("collide_t1", 64'(instr_valid_o), 64'(0));
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("collide_t2", 64'(instr_valid_o), 64'(0));
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("collide_t3", {31'(0), instr_valid_o, instr_addr_o}, {31'(0), 1'b1, 32'h0000_0400});

    // Random grants, latencies, stalls and redirects
    gnt_rand = 1'b1;
    lat_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) tick(1'b1, $urandom(), 1'b0, 1'b0);
      else tick(1'b0, 32'h0, ($urandom_range(0, 3) == 0), 1'b0);
    end
    gnt_rand = 1'b0;
    lat_rand = 1'b0;

    // Reset with one request outstanding and one entry buffered
    lat = 3;
    for (int i = 0; i < 10; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_empty", 64'(pend.size()), 64'(0));
    tick(1'b1, 32'h0000_3000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b1, 1'b0);
    check("mid_outstanding", 64'(pend.size()), 64'(1));
    check("mid_buffered", 64'(exp_q.size()), 64'(1));
    tick(1'b0, 32'h0, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("mid_rst_req", 64'(imem_req_o), 64'(0));
    check("mid_rst_valid", 64'(instr_valid_o), 64'(0));
    check("mid_rst_issued", 64'(instr_issued_o), 64'(0));
    check("mid_rst_addr", 64'(imem_addr_o), 64'(0));
    check("mid_rst_instr", {instr_addr_o, instr_o}, 64'(0));
    check("mid_rst_state", 64'(dbg_state_o), 64'(0));
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 1'b0, 1'b0);
      check("post_rst_req", 64'(imem_req_o), 64'(0));
      check("post_rst_valid", 64'(instr_valid_o), 64'(0));
    end
    lat = 1;
    track_first = 1'b1;
    first_seen = 1'b0;
    tick(1'b1, 32'h0000_0040, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 32'h0, 1'b0, 1'b0);
    check("restart_first", {31'(0), first_seen, first_addr}, {31'(0), 1'b1, 32'h0000_0040});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
